manchester_rx_frame: RTL and testbench

Parametrised Manchester receive decoder, the successor to the team's single-shot Manchester FSM. It sits between the serial input pin and the frame consumer. It detects a long-run preamble, decodes a configurable number of data bits plus an optional parity bit, and flags code violations. Timing-tolerant edge classification replaces fixed-count sampling.

---
 rtl/manchester_rx_frame_pkg.sv | 19 +
 rtl/manchester_edge_det.sv | 44 ++++
 rtl/manchester_rx_frame.sv | 167 ++++++++++++++++
 tb/tb_manchester_rx_frame.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/manchester_rx_frame_pkg.sv
// Shared constants for the Manchester frame receiver.
// Holds the FSM state codes and the jitter-window bound helpers.
package manchester_rx_frame_pkg;

    // FSM state encoding; codes 3..7 are unused and fall back to IDLE
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SYNC_HI = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;

    // Window W(n) = [n*h - tol, n*h + tol]
    function automatic int win_lo(input int n, input int h, input int tol);
        return n * h - tol;
    endfunction

    function automatic int win_hi(input int n, input int h, input int tol);
        return n * h + tol;
    endfunction

endpackage

// File: rtl/manchester_edge_det.sv
// Input conditioner: two-flop synchroniser, previous-value flop and
// registered edge pulses.
//   clk  in   system clock
//   rst  in   synchronous active-high reset
//   data in   raw asynchronous serial line
//   pos  out  one-cycle pulse on a synchronised rising edge
//   neg  out  one-cycle pulse on a synchronised falling edge
module manchester_edge_det
    import manchester_rx_frame_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic data,
    output logic pos,
    output logic neg
);

    logic r_s1;
    logic r_s2;
    logic r_q;
    logic r_pos;
    logic r_neg;

    // Pulses are registered, giving 3 clk from a pin change to pos/neg
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_q   <= 1'b0;
            r_pos <= 1'b0;
            r_neg <= 1'b0;
        end else begin
            r_s1  <= data;
            r_s2  <= r_s1;
            r_q   <= r_s2;
            r_pos <= r_s2 & ~r_q;
            r_neg <= ~r_s2 & r_q;
        end
    end

    assign pos = r_pos;
    assign neg = r_neg;

endmodule

// File: rtl/manchester_rx_frame.sv
// Manchester receive decoder: preamble detect, timing-tolerant edge
// classification, frame assembly with optional even parity.
//   clk, rst         clock, synchronous active-high reset
//   data             raw serial line (asynchronous)
//   pos, neg         synchronised edge pulses
//   stat             FSM state (0 IDLE, 1 SYNC_HI, 2 DATA)
//   count            bits decoded in the current frame
//   dout/dout_valid  last complete frame and its update strobe
//   parity_err       parity mismatch, qualified by dout_valid
//   code_err         pulse on a Manchester or timing violation
//   busy             high while in SYNC_HI or DATA
module manchester_rx_frame
    import manchester_rx_frame_pkg::*;
#(
    parameter int H          = 4,
    parameter int TOL        = 1,
    parameter int FRAME_BITS = 8,
    parameter int PARITY_EN  = 1,
    parameter int IEEE       = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            data,
    output logic                            pos,
    output logic                            neg,
    output logic [2:0]                      stat,
    output logic [$clog2(FRAME_BITS+2)-1:0] count,
    output logic [FRAME_BITS-1:0]           dout,
    output logic                            dout_valid,
    output logic                            parity_err,
    output logic                            code_err,
    output logic                            busy
);

    localparam int TW = $clog2(4 * H + 1);
    localparam int CW = $clog2(FRAME_BITS + 2);
    localparam int NB = FRAME_BITS + PARITY_EN;

    // t reads as clocks elapsed since the anchor cycle: the anchor
    // itself counts as 0, so an anchor loads 1 for the following cycle.
    localparam logic [TW-1:0] T_ONE   = TW'(1);
    localparam logic [TW-1:0] T_PRE   = TW'(H + 1);
    localparam logic [TW-1:0] T_MAX   = TW'(4 * H);
    localparam logic [TW-1:0] T_RUN   = TW'(3 * H - TOL);
    localparam logic [TW-1:0] T_BND   = TW'((3 * H + 1) / 2);
    localparam logic [TW-1:0] T_W1_LO = TW'(win_lo(1, H, TOL));
    localparam logic [TW-1:0] T_W1_HI = TW'(win_hi(1, H, TOL));
    localparam logic [TW-1:0] T_W2_LO = TW'(win_lo(2, H, TOL));
    localparam logic [TW-1:0] T_W2_HI = TW'(win_hi(2, H, TOL));
    localparam logic [TW-1:0] T_W3_LO = TW'(win_lo(3, H, TOL));
    localparam logic [TW-1:0] T_W3_HI = TW'(win_hi(3, H, TOL));
    // Timeouts fire on the cycle t would step onto the limit
    localparam logic [TW-1:0] T_STMO  = TW'(4 * H - 1);
    localparam logic [TW-1:0] T_DTMO  = TW'(2 * H + TOL);
    localparam logic [CW-1:0] C_LAST  = CW'(NB - 1);

    logic                  w_pos;
    logic                  w_neg;
    logic                  w_edge;
    logic                  w_bit;
    logic                  w_bnd;
    logic                  w_mid;
    logic                  w_sync_ok;
    logic [NB-1:0]         w_sh_nx;

    logic [2:0]            r_state;
    logic [TW-1:0]         r_t;
    logic [CW-1:0]         r_cnt;
    logic [NB-2:0]         r_sh;
    logic [FRAME_BITS-1:0] r_dout;
    logic                  r_dv;
    logic                  r_perr;
    logic                  r_cerr;

    manchester_edge_det u_edge (
        .clk  (clk),
        .rst  (rst),
        .data (data),
        .pos  (w_pos),
        .neg  (w_neg)
    );

    assign w_edge    = w_pos | w_neg;
    assign w_bit     = (IEEE != 0) ? w_pos : w_neg;
    assign w_bnd     = (r_t < T_BND) && (r_t >= T_W1_LO) && (r_t <= T_W1_HI);
    assign w_mid     = (r_t >= T_W2_LO) && (r_t <= T_W2_HI);
    assign w_sync_ok = (r_t >= T_W3_LO) && (r_t <= T_W3_HI);
    assign w_sh_nx   = {r_sh, w_bit};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_t     <= '0;
            r_cnt   <= '0;
            r_sh    <= '0;
            r_dout  <= '0;
            r_dv    <= 1'b0;
            r_perr  <= 1'b0;
            r_cerr  <= 1'b0;
        end else begin
            r_dv   <= 1'b0;
            r_perr <= 1'b0;
            r_cerr <= 1'b0;
            r_t    <= (r_t < T_MAX) ? r_t + T_ONE : r_t;
            case (r_state)
                ST_IDLE: begin
                    // t doubles as the line-level run counter here
                    if (w_edge) begin
                        r_t <= T_ONE;
                        if (w_pos && (r_t >= T_RUN)) begin
                            r_state <= ST_SYNC_HI;
                        end
                    end
                end
                ST_SYNC_HI: begin
                    if (w_neg && w_sync_ok) begin
                        // This fall is a bit boundary: mid-bit is H away
                        r_state <= ST_DATA;
                        r_t     <= T_PRE;
                        r_cnt   <= '0;
                        r_sh    <= '0;
                    end else if (w_edge || (r_t == T_STMO)) begin
                        r_state <= ST_IDLE;
                        r_t     <= T_ONE;
                        r_cerr  <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_edge && w_mid) begin
                        r_sh  <= w_sh_nx[NB-2:0];
                        r_cnt <= r_cnt + CW'(1);
                        r_t   <= T_ONE;
                        if (r_cnt == C_LAST) begin
                            r_state <= ST_IDLE;
                            r_dout  <= w_sh_nx[NB-1:PARITY_EN];
                            r_dv    <= 1'b1;
                            r_perr  <= (PARITY_EN != 0) && (^w_sh_nx);
                        end
                    end else if (w_edge && !w_bnd) begin
                        r_state <= ST_IDLE;
                        r_t     <= T_ONE;
                        r_cerr  <= 1'b1;
                    end else if (!w_edge && (r_t == T_DTMO)) begin
                        r_state <= ST_IDLE;
                        r_t     <= T_ONE;
                        r_cerr  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_t     <= T_ONE;
                end
            endcase
        end
    end

    assign pos        = w_pos;
    assign neg        = w_neg;
    assign stat       = r_state;
    assign count      = r_cnt;
    assign dout       = r_dout;
    assign dout_valid = r_dv;
    assign parity_err = r_perr;
    assign code_err   = r_cerr;
    assign busy       = (r_state == ST_SYNC_HI) || (r_state == ST_DATA);

endmodule

// File: tb/tb_manchester_rx_frame.sv
// Scoreboard bench for manchester_rx_frame: directed frames, timeouts,
// mid-frame reset and jittered back-to-back frames.
module tb_manchester_rx_frame;
    import manchester_rx_frame_pkg::*;

    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       data = 1'b1;
    logic       pos;
    logic       neg;
    logic [2:0] stat;
    logic [3:0] count;
    logic [7:0] dout;
    logic       dout_valid;
    logic       parity_err;
    logic       code_err;
    logic       busy;

    manchester_rx_frame #(
        .H(4), .TOL(1), .FRAME_BITS(8), .PARITY_EN(1), .IEEE(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .pos        (pos),
        .neg        (neg),
        .stat       (stat),
        .count      (count),
        .dout       (dout),
        .dout_valid (dout_valid),
        .parity_err (parity_err),
        .code_err   (code_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] d;
        logic       perr;
        int         at;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_dout = 8'h00;
    int         jpat[4] = '{0, 1, 0, -1};

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    // kind: 0 = expect a frame, 1 = expect a timeout code_err, 2 = none
    task automatic send(input logic [7:0] d, input logic par,
                        input int nbits, input bit jit,
                        input int plo, input int phi, input int kind);
        logic [8:0] w;
        logic       b;
        int         j;
        exp_t       e;
        w = {d, par};
        data = 1'b0;
        hold(plo);
        data = 1'b1;
        hold(phi);
        for (int i = 0; i < nbits; i++) begin
            b = w[8-i];
            j = jit ? jpat[i % 4] : 0;
            if (i == 0 && b == 1'b0) begin
                // Leading 0 must start high right after the preamble
                // fall; its boundary rise lands one clock late.
                data = 1'b0;
                hold(1);
                data = 1'b1;
                hold(H + j - 1);
            end else begin
                data = ~b;
                hold(H + j);
            end
            data = b;
            if (i == nbits - 1 && kind == 0) begin
                // 3 clk synchroniser, decode cycle, then output register
                e.is_err = 1'b0;
                e.d      = d;
                e.perr   = ^w;
                e.at     = cyc + 4;
                exp_dout = d;
                sb.push_back(e);
            end else if (i == nbits - 1 && kind == 1) begin
                // 3 clk synchroniser plus 2H+TOL+1 of silence
                e.is_err = 1'b1;
                e.d      = exp_dout;
                e.perr   = 1'b0;
                e.at     = cyc + 13;
                sb.push_back(e);
            end
            hold(H - j);
        end
    endtask

    logic prev_busy = 1'b0;
    exp_t m;

    always @(negedge clk) begin
        if (!rst && (dout_valid || code_err)) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: dout_valid=%0b code_err=%0b dout=%0h, required none",
                         dout_valid, code_err, dout);
            end else begin
                m = sb.pop_front();
                check("event_is_code_err", int'(code_err), int'(m.is_err));
                check("event_cycle", cyc, m.at);
                check("dout", int'(dout), int'(m.d));
                check("stat_after_event", int'(stat), 0);
                check("busy_after_event", int'(busy), 0);
                if (!m.is_err) begin
                    check("parity_err", int'(parity_err), int'(m.perr));
                    check("busy_before_valid", int'(prev_busy), 1);
                end
            end
        end
        prev_busy = busy;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        hold(3);
        check("rst_stat", int'(stat), 0);
        check("rst_count", int'(count), 0);
        check("rst_dout", int'(dout), 0);
        check("rst_dout_valid", int'(dout_valid), 0);
        check("rst_parity_err", int'(parity_err), 0);
        check("rst_code_err", int'(code_err), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pos", int'(pos), 0);
        check("rst_neg", int'(neg), 0);
        rst = 1'b0;

        // Short low run: rise must not start a frame
        hold(10);
        data = 1'b0;
        hold(8);
        data = 1'b1;
        hold(12);
        check("short_pre_stat", int'(stat), 0);
        check("short_pre_busy", int'(busy), 0);
        data = 1'b0;
        hold(20);
        check("short_pre_idle", int'(stat), 0);

        // 0xA5 with good and bad parity
        send(8'hA5, 1'b0, 9, 1'b0, 12, 12, 0);
        send(8'hA5, 1'b1, 9, 1'b0, 12, 12, 0);

        // Three bits then a frozen line: timeout, dout held
        send(8'hA5, 1'b0, 3, 1'b0, 12, 12, 1);
        hold(20);
        check("frozen_stat", int'(stat), 0);
        check("frozen_dout", int'(dout), 8'hA5);

        // Reset after the 4th bit, then a full 0x3C frame
        send(8'h3C, 1'b0, 4, 1'b0, 12, 12, 2);
        check("mid_count", int'(count), 4);
        check("mid_stat", int'(stat), 2);
        rst = 1'b1;
        hold(1);
        check("mrst_stat", int'(stat), 0);
        check("mrst_count", int'(count), 0);
        check("mrst_dout", int'(dout), 0);
        check("mrst_flags", int'({dout_valid, parity_err, code_err}), 0);
        check("mrst_busy", int'(busy), 0);
        check("mrst_edges", int'({pos, neg}), 0);
        rst = 1'b0;
        exp_dout = 8'h00;
        send(8'h3C, 1'b0, 9, 1'b0, 12, 12, 0);

        // Back-to-back jittered frames
        send(8'h01, 1'b1, 9, 1'b1, 11, 13, 0);
        send(8'hFF, 1'b0, 9, 1'b1, 13, 11, 0);

        hold(30);
        check("pending_expected_events", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
